// File: rtl/if_stage_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
  localparam logic [31:0] INST_NOP         = 32'h0340_0000;  // andi r0,r0,0

  typedef enum logic [1:0] {
    FETCH_ADVANCE,
    FETCH_STALL,
    FETCH_REDIRECT
  } fetch_op_e;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry capture/hold register that freezes a stalled instruction word
// so the ROM does not have to be re-read.
module fetch_hold_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture,
  input  logic        clear,
  input  logic [31:0] rdata,
  output logic        hold_valid,
  output logic [31:0] hold_inst
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_inst  <= '0;
    end else if (clear) begin
      hold_valid <= 1'b0;
    end else if (capture) begin
      hold_valid <= 1'b1;
      hold_inst  <= rdata;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: fetch PC, synchronous ROM addressing, decode
// stall handling with a hold buffer, and EX-stage redirect.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  output logic        irom_en,
  output logic [31:0] irom_addr,
  input  logic [31:0] irom_rdata,
  input  logic        id_stall,
  input  logic        ex_redirect,
  input  logic [31:0] ex_redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  fetch_op_e   op;
  logic [31:0] f_pc;
  logic [31:0] r_pc;
  logic        r_valid;
  logic [31:0] target;
  logic        capture;
  logic        clear;
  logic        hold_valid;
  logic [31:0] hold_inst;

  // Redirect outranks stall: the stalled instruction is wrong-path anyway.
  always_comb begin
    op = FETCH_ADVANCE;
    if (ex_redirect) begin
      op = FETCH_REDIRECT;
    end else if (id_stall) begin
      op = FETCH_STALL;
    end
  end

  assign target    = align_word(ex_redirect_pc);
  assign irom_en   = ~cpu_rst & (op != FETCH_STALL);
  assign irom_addr = (op == FETCH_REDIRECT) ? target : f_pc;

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      f_pc    <= RESET_PC;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else begin
      case (op)
        FETCH_REDIRECT: begin
          f_pc    <= pc_plus4(target);
          r_pc    <= target;
          r_valid <= 1'b1;
        end
        FETCH_ADVANCE: begin
          f_pc    <= pc_plus4(f_pc);
          r_pc    <= f_pc;
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Capture only on the first stalled cycle; later cycles keep the held word.
  assign capture = (op == FETCH_STALL) & r_valid & ~hold_valid;
  assign clear   = (op != FETCH_STALL);

  fetch_hold_buf u_hold (
    .clk       (cpu_clk),
    .rst       (cpu_rst),
    .capture   (capture),
    .clear     (clear),
    .rdata     (irom_rdata),
    .hold_valid(hold_valid),
    .hold_inst (hold_inst)
  );

  assign id_pc    = r_pc;
  assign id_valid = r_valid & ~ex_redirect;
  assign id_inst  = !r_valid ? INST_NOP : (hold_valid ? hold_inst : irom_rdata);

endmodule
